// File: rtl/ibex_fetch_align_fifo.sv
// Instruction fetch FIFO: buffers fetched words with their error flags, realigns
// compressed and unaligned instructions into one per handshake, and tracks the PC.
module ibex_fetch_align_fifo #(
  parameter int unsigned DEPTH     = 3,
  parameter bit          RV32C     = 1'b1,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [31:0]                branch_addr_i,
  input  logic                       in_valid_i,
  input  logic [31:0]                in_rdata_i,
  input  logic                       in_err_i,
  output logic                       in_ready_o,
  output logic [$clog2(DEPTH+1)-1:0] free_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_rdata_o,
  output logic [31:0]                out_addr_o,
  output logic                       out_err_o,
  output logic                       out_err_plus2_o,
  output logic                       busy_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  // Without compressed support the PC can never sit on a half-word boundary.
  localparam logic [31:0] PC_MASK = RV32C ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

  logic [31:0]      mem_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      w0;
  logic [15:0]      w1_lo;
  logic             e0, e1;
  logic             unaligned, is_c, has1, has2;
  logic             push, pop, fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_ptr_nxt = ptr_inc(rd_ptr_q);
  assign w0         = mem_q[rd_ptr_q];
  assign w1_lo      = mem_q[rd_ptr_nxt][15:0];
  assign e0         = err_q[rd_ptr_q];
  assign e1         = err_q[rd_ptr_nxt];

  assign unaligned  = RV32C && pc_q[1];
  assign is_c       = RV32C && ((unaligned ? w0[17:16] : w0[1:0]) != 2'b11);
  assign has1       = (count_q != '0);
  assign has2       = (count_q >= CNT_W'(2));

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    out_valid_o     = 1'b0;
    out_rdata_o     = w0;
    out_err_o       = 1'b0;
    out_err_plus2_o = 1'b0;
    if (!unaligned) begin
      out_valid_o = has1;
      out_err_o   = has1 & e0;
    end else if (is_c) begin
      out_valid_o = has1;
      out_rdata_o = {16'h0000, w0[31:16]};
      out_err_o   = has1 & e0;
    end else begin
      // An error in the first half is reported without waiting for the second word.
      out_valid_o     = has2 | (has1 & e0);
      out_rdata_o     = {w1_lo, w0[31:16]};
      out_err_o       = out_valid_o & (e0 | e1);
      out_err_plus2_o = out_valid_o & ~e0 & e1;
    end
  end

  assign in_ready_o = (count_q < CNT_W'(DEPTH));
  assign free_o     = CNT_W'(DEPTH) - count_q;
  assign busy_o     = has1;
  assign out_addr_o = pc_q;

  assign push = in_valid_i & in_ready_o & ~clear_i;
  assign fire = out_valid_o & out_ready_i & ~clear_i;
  // An aligned compressed instruction leaves its upper half in the head entry.
  assign pop  = fire & (unaligned | ~is_c);

  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    if (clear_i) begin
      count_d = '0;
      pc_d    = branch_addr_i & PC_MASK;
    end else begin
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
      if (fire) begin
        pc_d = pc_q + (is_c ? 32'd2 : 32'd4);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      pc_q     <= BOOT_ADDR & PC_MASK;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      if (clear_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= rd_ptr_nxt;
      end
    end
  end

  // NOTE: the word store is reset too, because the reset state defines entries and error flags as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      err_q <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_rdata_i;
      err_q[wr_ptr_q] <= in_err_i;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Directed bench for ibex_fetch_align_fifo: stimulus queues expected instructions,
// a negedge monitor compares them at every output handshake.
module tb_ibex_fetch_align_fifo;

  localparam int unsigned DEPTH     = 3;
  localparam logic [31:0] BOOT_ADDR = 32'h0000_0080;
  localparam logic [31:0] FULL      = 32'hFFFF_FFFF;
  localparam logic [31:0] HALF      = 32'h0000_FFFF;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] mask;
    logic [31:0] addr;
    logic        err;
    logic        plus2;
  } exp_t;

  logic        clk, rst_n, clear;
  logic [31:0] branch_addr;
  logic        in_valid, in_err, in_ready;
  logic [31:0] in_rdata;
  logic [1:0]  free;
  logic        out_valid, out_ready, out_err, out_err_plus2, busy;
  logic [31:0] out_rdata, out_addr;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  ibex_fetch_align_fifo #(
    .DEPTH    (DEPTH),
    .RV32C    (1'b1),
    .BOOT_ADDR(BOOT_ADDR)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .branch_addr_i  (branch_addr),
    .in_valid_i     (in_valid),
    .in_rdata_i     (in_rdata),
    .in_err_i       (in_err),
    .in_ready_o     (in_ready),
    .free_o         (free),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_rdata_o    (out_rdata),
    .out_addr_o     (out_addr),
    .out_err_o      (out_err),
    .out_err_plus2_o(out_err_plus2),
    .busy_o         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_instr(input logic [31:0] rdata, input logic [31:0] mask,
                           input logic [31:0] addr, input logic err, input logic plus2);
    exp_t e;
    e.rdata = rdata;
    e.mask  = mask;
    e.addr  = addr;
    e.err   = err;
    e.plus2 = plus2;
    sb.push_back(e);
  endtask

  task automatic do_clear(input logic [31:0] addr);
    clear       = 1'b1;
    branch_addr = addr;
    tick();
    clear       = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] data, input logic err);
    in_valid = 1'b1;
    in_rdata = data;
    in_err   = err;
    tick();
    in_valid = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d instructions still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clear) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got addr 0x%08h rdata 0x%08h, expected no instruction",
                 out_addr, out_rdata);
      end else begin
        mon_e = sb.pop_front();
        check("instr_rdata", out_rdata & mon_e.mask, mon_e.rdata & mon_e.mask);
        check("instr_addr", out_addr, mon_e.addr);
        check("instr_err", 32'(out_err), 32'(mon_e.err));
        check("instr_err_plus2", 32'(out_err_plus2), 32'(mon_e.plus2));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    branch_addr = '0;
    in_valid    = 1'b0;
    in_rdata    = '0;
    in_err      = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_free", 32'(free), 32'(DEPTH));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_addr", out_addr, BOOT_ADDR);
    rst_n = 1'b1;
    tick();

    // Aligned 32-bit instruction; bit 0 of the branch target is dropped.
    do_clear(32'h0000_0101);
    check("clear_addr", out_addr, 32'h0000_0100);
    in_valid = 1'b1;
    in_rdata = 32'h0000_0013;
    check("no_bypass_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_rdata", out_rdata, 32'h0000_0013);
    exp_instr(32'h0000_0013, FULL, 32'h0000_0100, 1'b0, 1'b0);
    drain();
    check("t1_addr_after", out_addr, 32'h0000_0104);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Two compressed instructions in one word: only the second pops it.
    do_clear(32'h0000_0200);
    push_word(32'h4501_4501, 1'b0);
    exp_instr(32'h0000_4501, HALF, 32'h0000_0200, 1'b0, 1'b0);
    exp_instr(32'h0000_4501, FULL, 32'h0000_0202, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check("t2_free_mid", 32'(free), 32'd2);
    check("t2_addr_mid", out_addr, 32'h0000_0202);
    tick();
    out_ready = 1'b0;
    check("t2_free_end", 32'(free), 32'd3);
    check("t2_addr_end", out_addr, 32'h0000_0204);

    // Unaligned 32-bit instruction waits for its second word; the leftover half is compressed.
    do_clear(32'h0000_0302);
    push_word(32'h0513_1111, 1'b0);
    check("t3_wait_valid", 32'(out_valid), 32'd0);
    push_word(32'hABCD_0000, 1'b0);
    check("t3_valid", 32'(out_valid), 32'd1);
    exp_instr(32'h0000_0513, FULL, 32'h0000_0302, 1'b0, 1'b0);
    exp_instr(32'h0000_ABCD, FULL, 32'h0000_0306, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check("t3_addr_mid", out_addr, 32'h0000_0306);
    check("t3_free_mid", 32'(free), 32'd2);
    tick();
    out_ready = 1'b0;
    check("t3_addr_end", out_addr, 32'h0000_0308);
    check("t3_busy_end", 32'(busy), 32'd0);

    // Error in the upper half of an unaligned instruction.
    do_clear(32'h0000_0402);
    push_word(32'h0297_0000, 1'b0);
    check("t4a_wait_valid", 32'(out_valid), 32'd0);
    push_word(32'h0000_0000, 1'b1);
    check("t4a_valid", 32'(out_valid), 32'd1);
    exp_instr(32'h0000_0297, FULL, 32'h0000_0402, 1'b1, 1'b1);
    drain();
    check("t4a_free", 32'(free), 32'd2);
    check("t4a_addr", out_addr, 32'h0000_0406);

    // Stale erroneous entry behind the head must not leak onto the error outputs.
    do_clear(32'h0000_0602);
    push_word(32'h0297_0000, 1'b0);
    check("t4b_wait_valid", 32'(out_valid), 32'd0);
    check("t4b_wait_err", 32'(out_err), 32'd0);
    check("t4b_wait_plus2", 32'(out_err_plus2), 32'd0);
    push_word(32'h0000_1111, 1'b0);
    exp_instr(32'h1111_0297, FULL, 32'h0000_0602, 1'b0, 1'b0);
    drain();
    check("t4b_addr", out_addr, 32'h0000_0606);

    // Error in the first half is presented with a single entry.
    do_clear(32'h0000_0702);
    push_word(32'hFFFF_FFFF, 1'b1);
    check("t4c_valid", 32'(out_valid), 32'd1);
    exp_instr(32'h0000_FFFF, HALF, 32'h0000_0702, 1'b1, 1'b0);
    drain();
    check("t4c_addr", out_addr, 32'h0000_0706);
    check("t4c_busy", 32'(busy), 32'd0);

    // Fill, refuse when full, then stream push+pop at DEPTH-1 across several wraps.
    do_clear(32'h0000_0800);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_rdata = 32'h0000_0013 + 32'(k << 12);
      exp_instr(32'h0000_0013 + 32'(k << 12), FULL, 32'h0000_0800 + 32'(4 * k), 1'b0, 1'b0);
      tick();
      check("t5_fill_free", 32'(free), 32'(2 - k));
    end
    in_rdata = 32'hDEAD_BEEF;
    check("t5_full_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    check("t5_full_free", 32'(free), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_free_after_pop", 32'(free), 32'd1);
    for (int j = 3; j < 12; j++) begin
      in_valid  = 1'b1;
      in_rdata  = 32'h0000_0013 + 32'(j << 12);
      out_ready = 1'b1;
      exp_instr(32'h0000_0013 + 32'(j << 12), FULL, 32'h0000_0800 + 32'(4 * j), 1'b0, 1'b0);
      tick();
      check("t5_stream_free", 32'(free), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drain();
    check("t5_addr_end", out_addr, 32'h0000_0830);
    check("t5_busy_end", 32'(busy), 32'd0);

    // Clear wins over a simultaneous push and pop.
    do_clear(32'h0000_0900);
    push_word(32'h0000_0013, 1'b0);
    check("t6_valid_before", 32'(out_valid), 32'd1);
    clear       = 1'b1;
    branch_addr = 32'h0000_0A01;
    in_valid    = 1'b1;
    in_rdata    = 32'h0000_0093;
    out_ready   = 1'b1;
    tick();
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t6_free", 32'(free), 32'd3);
    check("t6_addr", out_addr, 32'h0000_0A00);
    check("t6_valid", 32'(out_valid), 32'd0);

    // PC wraps modulo 2^32.
    do_clear(32'hFFFF_FFFE);
    push_word(32'h4501_4501, 1'b0);
    exp_instr(32'h0000_4501, FULL, 32'hFFFF_FFFE, 1'b0, 1'b0);
    drain();
    check("wrap_addr", out_addr, 32'h0000_0000);
    check("wrap_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-stream discards buffered words.
    do_clear(32'h0000_0B00);
    push_word(32'h0000_0013, 1'b0);
    push_word(32'h0000_0013, 1'b0);
    check("rst_mid_free_before", 32'(free), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_addr", out_addr, BOOT_ADDR);
    check("rst_mid_free", 32'(free), 32'(DEPTH));
    tick();
    rst_n = 1'b1;
    tick();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
